// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared definitions for the Mini-CPU sequencer
// Purpose: opcode codes, instruction field positions, default widths,
//          sequencer state encoding and small decode helpers.
// Ports:   none (package).
package cpu_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;
  localparam int INSTR_W    = 16;

  localparam logic [3:0] OP_LOAD    = 4'd0;
  localparam logic [3:0] OP_ADD     = 4'd1;
  localparam logic [3:0] OP_ADDI    = 4'd2;
  localparam logic [3:0] OP_SUB     = 4'd3;
  localparam logic [3:0] OP_SUBI    = 4'd4;
  localparam logic [3:0] OP_MUL     = 4'd5;
  localparam logic [3:0] OP_MULI    = 4'd6;
  localparam logic [3:0] OP_CLEAR   = 4'd7;
  localparam logic [3:0] OP_DISPLAY = 4'd8;

  // Instruction fields: [15:12] opcode, [11:8] dest, [7:4] src1,
  // [3:0] src2/imm4, [7:0] imm8 for LOAD.
  localparam int OP_LSB   = 12;
  localparam int DEST_LSB = 8;
  localparam int SRC1_LSB = 4;
  localparam int SRC2_LSB = 0;
  localparam int IMM8_LSB = 0;
  localparam int IMM4_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_EXEC  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  function automatic logic is_legal(input logic [3:0] op);
    return op <= OP_DISPLAY;
  endfunction

  // LOAD and every arithmetic opcode write their result back.
  function automatic logic writes_rf(input logic [3:0] op);
    return op <= OP_MULI;
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// rtl/cpu_alu.sv - combinational ALU for the Mini-CPU
// Purpose: computes the result and signed overflow for one opcode.
// Ports:
//   op_i       opcode (immediate forms share the register-form datapath)
//   a_i        first operand (src1 register value)
//   b_i        second operand (src2 value or sign-extended immediate)
//   result_o   wrapped DATA_W-bit result
//   overflow_o signed overflow for ADD/SUB/MUL families, else 0
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [3:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] result_o,
  output logic              overflow_o
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W-1:0]          sum;
  logic [DATA_W-1:0]          diff;
  logic signed [2*DATA_W-1:0] a_ext;
  logic signed [2*DATA_W-1:0] b_ext;
  logic signed [2*DATA_W-1:0] prod;

  assign sum   = a_i + b_i;
  assign diff  = a_i - b_i;
  assign a_ext = {{DATA_W{a_i[MSB]}}, a_i};
  assign b_ext = {{DATA_W{b_i[MSB]}}, b_i};
  assign prod  = a_ext * b_ext;

  always_comb begin
    result_o   = '0;
    overflow_o = 1'b0;
    case (op_i)
      OP_LOAD: result_o = b_i;
      OP_ADD, OP_ADDI: begin
        result_o   = sum;
        overflow_o = (a_i[MSB] == b_i[MSB]) && (sum[MSB] != a_i[MSB]);
      end
      OP_SUB, OP_SUBI: begin
        result_o   = diff;
        overflow_o = (a_i[MSB] != b_i[MSB]) && (diff[MSB] != a_i[MSB]);
      end
      OP_MUL, OP_MULI: begin
        result_o   = prod[DATA_W-1:0];
        // Fits in signed DATA_W only if the upper half is a pure sign copy.
        overflow_o = prod[2*DATA_W-1:DATA_W-1] != {(DATA_W+1){prod[MSB]}};
      end
      OP_CLEAR:   result_o = '0;
      OP_DISPLAY: result_o = a_i;
      default:    result_o = a_i;
    endcase
  end

endmodule

// File: rtl/cpu_control.sv
// rtl/cpu_control.sv - Mini-CPU instruction sequencer
// Purpose: accepts one instruction per valid/ready transfer, walks it through
//          READ/EXEC/WRITE/DONE and drives the register file access side.
// Ports:
//   clock, reset                  clock and async active-high reset
//   instr_valid/instr_ready/instr instruction handshake
//   rf_addr_src1/2, rf_out_src1/2 register file read side
//   rf_we/rf_addr_dest/rf_data_in register file write side
//   rf_clear                      one-cycle clear-all pulse
//   result/overflow/illegal       status of the last executed instruction
//   done                          one-cycle completion pulse
module cpu_control
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  rf_addr_src1,
  output logic [ADDR_W-1:0]  rf_addr_src2,
  input  logic [DATA_W-1:0]  rf_out_src1,
  input  logic [DATA_W-1:0]  rf_out_src2,
  output logic               rf_we,
  output logic [ADDR_W-1:0]  rf_addr_dest,
  output logic [DATA_W-1:0]  rf_data_in,
  output logic               rf_clear,
  output logic [DATA_W-1:0]  result,
  output logic               done,
  output logic               overflow,
  output logic               illegal
);

  state_e               state_q, state_d;
  logic [INSTR_W-1:0]   instr_q;
  logic [DATA_W-1:0]    result_q;
  logic                 overflow_q;
  logic                 illegal_q;

  logic [3:0]           op;
  logic [7:0]           imm8;
  logic [3:0]           imm4;
  logic [DATA_W-1:0]    operand_b;
  logic [DATA_W-1:0]    alu_result;
  logic                 alu_overflow;
  logic                 accept;

  assign op   = instr_q[OP_LSB +: 4];
  assign imm8 = instr_q[IMM8_LSB +: 8];
  assign imm4 = instr_q[IMM4_LSB +: 4];

  always_comb begin
    operand_b = rf_out_src2;
    case (op)
      OP_LOAD:                    operand_b = {{(DATA_W-8){imm8[7]}}, imm8};
      OP_ADDI, OP_SUBI, OP_MULI:  operand_b = {{(DATA_W-4){imm4[3]}}, imm4};
      default:                    operand_b = rf_out_src2;
    endcase
  end

  cpu_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op_i       (op),
    .a_i        (rf_out_src1),
    .b_i        (operand_b),
    .result_o   (alu_result),
    .overflow_o (alu_overflow)
  );

  assign accept = (state_q == S_IDLE) && instr_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instr_q    <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      if (accept) begin
        instr_q <= instr;
      end
      // Status registers update only at the end of EXEC; an illegal opcode
      // leaves the previous result visible.
      if (state_q == S_EXEC) begin
        illegal_q  <= !is_legal(op);
        overflow_q <= is_legal(op) && alu_overflow;
        if (is_legal(op)) begin
          result_q <= alu_result;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    rf_we       = 1'b0;
    rf_clear    = 1'b0;
    done        = 1'b0;
    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = S_READ;
      end
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WRITE;
      S_WRITE: begin
        rf_we    = writes_rf(op);
        rf_clear = (op == OP_CLEAR);
        state_d  = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rf_addr_src1 = instr_q[SRC1_LSB +: ADDR_W];
  assign rf_addr_src2 = instr_q[SRC2_LSB +: ADDR_W];
  assign rf_addr_dest = instr_q[DEST_LSB +: ADDR_W];
  assign rf_data_in   = result_q;
  assign result       = result_q;
  assign overflow     = overflow_q;
  assign illegal      = illegal_q;

endmodule
